mips_dmem_responder: RTL and testbench

//  Responder side of the CPU data-memory port (memwrite/memaddr/memwritedata -> memreaddata).

---
 rtl/mips_mmio_pkg.sv | 32 +++
 rtl/mips_dmem_responder_if.sv | 21 ++
 rtl/mips_dmem_responder_tx_fifo.sv | 56 +++++
 rtl/mips_dmem_responder.sv | 125 ++++++++++++
 tb/tb_mips_dmem_responder.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_mmio_pkg.sv
// Shared constants for the CPU data-memory responder: MMIO page, register map,
// STATUS bit layout and timer reset value.
package mips_mmio_pkg;

  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
  localparam logic [27:0] MMIO_PAGE  = 28'hFFFF_000;
  localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    REG_TCNT   = 2'd0,
    REG_TCMP   = 2'd1,
    REG_STATUS = 2'd2,
    REG_TXDATA = 2'd3
  } mmio_reg_e;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_MATCH = 2;
  localparam int ST_OVF   = 3;

  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic match, input logic ovf);
    logic [31:0] w;
    w           = '0;
    w[ST_FULL]  = full;
    w[ST_EMPTY] = empty;
    w[ST_MATCH] = match;
    w[ST_OVF]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/mips_dmem_responder_if.sv
// CPU data-memory port plus the TX byte stream and timer interrupt of the responder.
interface mips_dmem_responder_if;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        irq;

  modport master (
    output memwrite, memaddr, memwritedata, tx_ready,
    input  memreaddata, tx_valid, tx_data, irq
  );

  modport slave (
    input  memwrite, memaddr, memwritedata, tx_ready,
    output memreaddata, tx_valid, tx_data, irq
  );
endinterface

// File: rtl/mips_dmem_responder_tx_fifo.sv
// Synchronous byte FIFO for the MMIO TX path; head/valid come straight from
// registered state so a byte pushed into an empty FIFO shows up one cycle later.
module mmio_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          push_ok, pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  // Storage is never reset, so mask the head while empty to keep it at zero.
  assign head    = empty ? 8'h00 : mem_reg[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end
endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS core: word RAM plus an MMIO page with a TX
// byte FIFO and, when MIPS_MMIO_TIMER_EN is defined, a free-running compare timer.
module mips_dmem_responder
  import mips_mmio_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input logic                  clk,
  input logic                  reset,
  mips_dmem_responder_if.slave bus
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          ram_hit, mmio_hit;
  mmio_reg_e     reg_sel;
  logic [AW-1:0] ram_idx;
  logic          wr_tcnt, wr_tcmp, wr_status, wr_tx;
  logic          unused_addr_bits;

  assign ram_hit   = (bus.memaddr[31:AW+2] == '0);
  assign mmio_hit  = (bus.memaddr[31:4] == MMIO_PAGE);
  assign reg_sel   = mmio_reg_e'(bus.memaddr[3:2]);
  assign ram_idx   = bus.memaddr[AW+1:2];
  assign wr_tcnt   = bus.memwrite & mmio_hit & (reg_sel == REG_TCNT);
  assign wr_tcmp   = bus.memwrite & mmio_hit & (reg_sel == REG_TCMP);
  assign wr_status = bus.memwrite & mmio_hit & (reg_sel == REG_STATUS);
  assign wr_tx     = bus.memwrite & mmio_hit & (reg_sel == REG_TXDATA);
  assign unused_addr_bits = ^bus.memaddr[1:0];

  // Asynchronous read so loads complete in the MEM stage; old word on read-during-write.
  logic [31:0] ram_mem [RAM_WORDS];
  always_ff @(posedge clk) begin
    if (bus.memwrite && ram_hit) ram_mem[ram_idx] <= bus.memwritedata;
  end

  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;

  mmio_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_tx),
    .push_data (bus.memwritedata[7:0]),
    .pop       (~fifo_empty & bus.tx_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign bus.tx_valid = ~fifo_empty;
  assign bus.tx_data  = fifo_head;

  // Overflow is judged against pre-edge fullness; a set beats a same-cycle clear.
  logic ovf_reg, ovf_next;
  always_comb begin
    ovf_next = ovf_reg;
    if (wr_status && bus.memwritedata[ST_OVF]) ovf_next = 1'b0;
    if (wr_tx && fifo_full)                    ovf_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) ovf_reg <= 1'b0;
    else        ovf_reg <= ovf_next;
  end

  logic [31:0] tcnt_rd, tcmp_rd;
  logic        match_flag;

`ifdef MIPS_MMIO_TIMER_EN
  logic [31:0] tcnt_reg, tcnt_next, tcmp_reg, tcmp_next;
  logic        match_reg, match_next;

  always_comb begin
    tcnt_next  = wr_tcnt ? bus.memwritedata : tcnt_reg + 32'd1;
    tcmp_next  = wr_tcmp ? bus.memwritedata : tcmp_reg;
    match_next = match_reg;
    if (wr_status && bus.memwritedata[ST_MATCH]) match_next = 1'b0;
    if (tcnt_next == tcmp_reg)                   match_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt_reg  <= '0;
      tcmp_reg  <= TCMP_RESET;
      match_reg <= 1'b0;
    end else begin
      tcnt_reg  <= tcnt_next;
      tcmp_reg  <= tcmp_next;
      match_reg <= match_next;
    end
  end

  assign tcnt_rd    = tcnt_reg;
  assign tcmp_rd    = tcmp_reg;
  assign match_flag = match_reg;
`else
  assign tcnt_rd    = '0;
  assign tcmp_rd    = '0;
  assign match_flag = 1'b0;
`endif

  assign bus.irq = match_flag;

  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = ram_mem[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_TCNT:   rdata = tcnt_rd;
        REG_TCMP:   rdata = tcmp_rd;
        REG_STATUS: rdata = status_word(fifo_full, fifo_empty, match_flag, ovf_reg);
        REG_TXDATA: rdata = 32'(fifo_count);
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.memreaddata = rdata;
endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed bench for mips_dmem_responder: RAM, MMIO FIFO, overflow, reset and
// (with MIPS_MMIO_TIMER_EN) timer compare/wrap checks.
module tb_mips_dmem_responder;
  localparam logic [31:0] A_TCNT   = 32'hFFFF_0000;
  localparam logic [31:0] A_TCMP   = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_000C;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  mips_dmem_responder_if bus();

  mips_dmem_responder #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
    $display("check %-14s got %h expected %h", tag, obs, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.memwrite     = 1'b1;
    bus.memaddr      = addr;
    bus.memwritedata = data;
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    bus.memaddr = addr;
    #1;
    check(tag, bus.memreaddata, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b0;
    bus.memwrite = 1'b0;
    bus.memaddr = '0;
    bus.memwritedata = '0;
    bus.tx_ready = 1'b0;

    // Reset state, sampled while reset is still asserted
    repeat (2) @(posedge clk);
    rd_check("rst_tcnt", A_TCNT, 32'h0);
`ifdef MIPS_MMIO_TIMER_EN
    rd_check("rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
`else
    rd_check("rst_tcmp", A_TCMP, 32'h0);
`endif
    check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    check("rst_irq", 32'(bus.irq), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rd_check("rst_status", A_STATUS, 32'h2);
    rd_check("rst_count", A_TXDATA, 32'h0);

    // RAM
    wr(32'h0000_0040, 32'h1234_5678);
    rd_check("ram_lw40", 32'h0000_0040, 32'h1234_5678);
    rd_check("ram_unmapped", 32'h1000_0000, 32'h0);
    @(negedge clk);
    bus.memwrite = 1'b1;
    bus.memaddr = 32'h0000_0040;
    bus.memwritedata = 32'hCAFE_F00D;
    #1;
    check("ram_rdw_old", bus.memreaddata, 32'h1234_5678);
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
    rd_check("ram_rdw_new", 32'h0000_0040, 32'hCAFE_F00D);
    wr(32'h0000_0000, 32'h0BAD_0001);
    wr(32'h0000_00FC, 32'h0BAD_00FC);
    wr(32'h0000_0100, 32'hDEAD_BEEF);
    wr(32'h1000_0000, 32'hDEAD_BEEF);
    rd_check("ram_word0", 32'h0000_0000, 32'h0BAD_0001);
    rd_check("ram_top", 32'h0000_00FC, 32'h0BAD_00FC);
    rd_check("ram_past_end", 32'h0000_0100, 32'h0);

    // FIFO fill with the consumer stalled
    wr(A_TXDATA, 32'h41);
    @(negedge clk);
    check("fifo_valid1", 32'(bus.tx_valid), 32'h1);
    check("fifo_head1", 32'(bus.tx_data), 32'h41);
    for (int i = 1; i < 8; i++) wr(A_TXDATA, 32'h41 + 32'(i));
    rd_check("fifo_full_st", A_STATUS, 32'h1);
    rd_check("fifo_count8", A_TXDATA, 32'h8);
    wr(A_TXDATA, 32'h49);
    rd_check("fifo_ovf_st", A_STATUS, 32'h9);
    check("fifo_head_hold", 32'(bus.tx_data), 32'h41);
    rd_check("fifo_count_ovf", A_TXDATA, 32'h8);
    wr(A_STATUS, 32'h8);
    rd_check("ovf_clear", A_STATUS, 32'h1);

    // Drain: one byte per cycle in push order
    @(negedge clk);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("drain_data", 32'(bus.tx_data), 32'h41 + 32'(i));
      @(negedge clk);
    end
    #1;
    check("drain_valid0", 32'(bus.tx_valid), 32'h0);
    bus.tx_ready = 1'b0;
    rd_check("drain_empty", A_STATUS, 32'h2);

    // Push and pop in the same cycle at count 3
    wr(A_TXDATA, 32'h51);
    wr(A_TXDATA, 32'h52);
    wr(A_TXDATA, 32'h53);
    @(negedge clk);
    bus.memwrite = 1'b1;
    bus.memaddr = A_TXDATA;
    bus.memwritedata = 32'h54;
    bus.tx_ready = 1'b1;
    #1;
    check("pp_head", 32'(bus.tx_data), 32'h51);
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
    bus.tx_ready = 1'b0;
    rd_check("pp_count", A_TXDATA, 32'h3);
    @(negedge clk);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("pp_order", 32'(bus.tx_data), 32'h52 + 32'(i));
      @(negedge clk);
    end
    #1;
    check("pp_empty", 32'(bus.tx_valid), 32'h0);
    bus.tx_ready = 1'b0;

`ifdef MIPS_MMIO_TIMER_EN
    // Compare match lands 20 edges after the TCNT write
    wr(A_TCMP, 32'd20);
    wr(A_TCNT, 32'd0);
    repeat (19) @(posedge clk);
    #1;
    check("tmr_irq_early", 32'(bus.irq), 32'h0);
    @(posedge clk);
    #1;
    check("tmr_irq_set", 32'(bus.irq), 32'h1);
    bus.memaddr = A_TCNT;
    #1;
    check("tmr_tcnt20", bus.memreaddata, 32'd20);
    rd_check("tmr_status", A_STATUS, 32'h6);
    wr(A_STATUS, 32'h4);
    check("tmr_irq_clr", 32'(bus.irq), 32'h0);
    wr(A_TCNT, 32'hFFFF_FFFE);
    bus.memaddr = A_TCNT;
    #1;
    check("tmr_wr_val", bus.memreaddata, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    check("tmr_ffff", bus.memreaddata, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check("tmr_wrap0", bus.memreaddata, 32'h0);
`else
    wr(A_TCNT, 32'h1234);
    wr(A_TCMP, 32'h0);
    rd_check("notmr_tcnt", A_TCNT, 32'h0);
    check("notmr_irq", 32'(bus.irq), 32'h0);
    wr(A_STATUS, 32'h0);
    rd_check("notmr_status", A_STATUS, 32'h2);
`endif

    // Reset in the middle of a stream
    wr(A_TXDATA, 32'h61);
    wr(A_TXDATA, 32'h62);
    @(negedge clk);
    check("mid_valid", 32'(bus.tx_valid), 32'h1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 32'(bus.tx_valid), 32'h0);
    rd_check("mid_rst_tcnt", A_TCNT, 32'h0);
    rd_check("mid_rst_count", A_TXDATA, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rd_check("mid_rst_st", A_STATUS, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
